dmem_responder: RTL
===================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 1024, number of 32-bit words of storage.
REQ-002 The block SHALL have parameter WAIT_CYCLES, default 0, extra cycles between request acceptance and response.
REQ-003 The block SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte address of word 0.
REQ-004 The block SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 The block SHALL have port req_valid, input, 1, request present.
REQ-007 The block SHALL have port req_ready, output, 1, request accepted this cycle when high with req_valid.
REQ-008 The block SHALL have port req_addr, input, 32, byte address; [1:0] is the byte lane.
REQ-009 The block SHALL have port req_we, input, 4, per-byte write strobes; bit n writes byte lane n.
REQ-010 The block SHALL have port req_wdata, input, 32, write data already shifted up to its lane by the requester.
REQ-011 The block SHALL have port req_re, input, 1, read request.
REQ-012 The block SHALL have port resp_valid, output, 1, response present.
REQ-013 The block SHALL have port resp_ready, input, 1, requester takes the response.
REQ-014 The block SHALL have port resp_rdata, output, 32, read data shifted down by req_addr[1:0]*8 with zero fill, so the addressed byte lands in bits [7:0].
REQ-015 The block SHALL have port resp_err, output, 1, request was illegal; qualified by resp_valid.

Function
REQ-016 The FSM SHALL have exactly the states IDLE, WAIT and RESP.
REQ-017 req_ready SHALL be 1 only in IDLE.
REQ-018 Acceptance SHALL be defined as req_valid && req_ready on a clock edge; the block SHALL latch addr, we, re and the computed error at that edge.
REQ-019 On acceptance the FSM SHALL go to WAIT with the counter loaded to WAIT_CYCLES-1 when WAIT_CYCLES>0, else directly to RESP.
REQ-020 In WAIT the counter SHALL decrement once per cycle, and the FSM SHALL go to RESP in the cycle after the counter reads 0.
REQ-021 resp_valid SHALL be 1 only in RESP; resp_rdata and resp_err SHALL stay stable while resp_valid && !resp_ready.
REQ-022 The FSM SHALL go from RESP to IDLE on resp_ready, so the minimum request-to-request period is 2 cycles (WAIT_CYCLES=0).
REQ-023 Legal req_we patterns SHALL be exactly 0000, 1111, 0011, 1100, 0001, 0010, 0100 and 1000.
REQ-024 Any other req_we pattern SHALL set resp_err=1 and suppress the write.
REQ-025 A request SHALL be out of range when (req_addr-BASE_ADDR)>>2 >= DEPTH_WORDS, or when req_addr < BASE_ADDR.
REQ-026 An out-of-range request SHALL set resp_err=1, suppress the write and return resp_rdata=0.
REQ-027 A write SHALL commit to storage at the acceptance edge, updating only the bytes whose strobe is set.
REQ-028 When both req_re and a write are present, resp_rdata SHALL return the word as it was before the write (read-before-write).
REQ-029 A request with req_re=0 SHALL return resp_rdata=0.
REQ-030 A request with req_we=0000 and req_re=0 SHALL be accepted and answered with resp_err=0.
REQ-031 An illegal request SHALL still complete the full handshake.

Reset
REQ-032 While rst=1, state SHALL be IDLE, the counter 0, resp_valid=0, resp_rdata=0, resp_err=0 and req_ready=0.
REQ-033 req_ready SHALL rise in the first cycle after rst deasserts.
REQ-034 rst asserted in WAIT or RESP SHALL drop the pending response, while a write already committed at acceptance remains.
REQ-035 Storage contents SHALL NOT be cleared by reset.

Structure
REQ-036 A shared package dmem_pkg SHALL hold the state enumeration, the legal strobe constants and a strobe-legality function.
REQ-037 One sub-module, dmem_ram, SHALL implement the byte-enabled word array: one write port and one read port, both addressed from the acceptance edge.

Verification
REQ-038 Word write then read: write addr 0x10, we=1111, wdata=0xDEADBEEF; read 0x10 -> resp_rdata=0xDEADBEEF, err=0.
REQ-039 Byte lanes: after REQ-038, write 0x13, we=1000, wdata=0x55000000; read 0x13 -> 0x00000055; read 0x10 -> 0x55ADBEEF.
REQ-040 Illegal strobe: write 0x20, we=0110 -> err=1; a read of 0x20 returns the unchanged prior word.
REQ-041 Range check: DEPTH_WORDS=16, read 0x40 -> err=1, rdata=0; read 0x3C -> err=0.
REQ-042 Wait and back-pressure: WAIT_CYCLES=3, resp_ready held low 2 cycles -> resp_valid rises exactly 4 cycles after acceptance and data stays stable; req_ready stays 0 until the cycle after resp_ready.
REQ-043 Reset mid-operation: WAIT_CYCLES=3, write 0x8 with 0x12345678, rst pulsed during WAIT -> no response; a later read of 0x8 returns 0x12345678.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM state encoding,
// the legal byte-strobe patterns and a helper that classifies a strobe.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] WE_NONE  = 4'b0000;
  localparam logic [3:0] WE_WORD  = 4'b1111;
  localparam logic [3:0] WE_HALF0 = 4'b0011;
  localparam logic [3:0] WE_HALF1 = 4'b1100;
  localparam logic [3:0] WE_BYTE0 = 4'b0001;
  localparam logic [3:0] WE_BYTE1 = 4'b0010;
  localparam logic [3:0] WE_BYTE2 = 4'b0100;
  localparam logic [3:0] WE_BYTE3 = 4'b1000;

  // True for aligned byte, halfword, word or no-write strobe patterns.
  function automatic logic strobe_legal(input logic [3:0] we);
    case (we)
      WE_NONE, WE_WORD, WE_HALF0, WE_HALF1,
      WE_BYTE0, WE_BYTE1, WE_BYTE2, WE_BYTE3: return 1'b1;
      default:                                return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bus between a load-store requester (master) and the
// data-memory responder (slave).
//   req_*  : request channel, valid/ready handshake, byte address + strobes
//   resp_* : response channel, valid/ready handshake, read data + error flag
interface dmem_responder_if;

  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [3:0]  req_we;
  logic [31:0] req_wdata;
  logic        req_re;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_addr, req_we, req_wdata, req_re, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_addr, req_we, req_wdata, req_re, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/dmem_ram.sv
// Byte-enabled word array with one write port and one asynchronous read port.
//   clk     : write clock
//   we      : per-byte write enables
//   waddr   : write word index
//   wdata   : write data, byte n in bits [8n+7:8n]
//   raddr   : read word index
//   rdata_c : current contents of word raddr (combinational)
module dmem_ram #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = 10
) (
  input  logic          clk,
  input  logic [3:0]    we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata_c
);

  logic [31:0] mem [DEPTH];

  // Reading before the edge gives the caller the pre-write word.
  assign rdata_c = mem[raddr];

  // Per-lane write; storage has no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder. Accepts one request in IDLE,
// commits any write at the acceptance edge, optionally waits WAIT_CYCLES,
// then holds the response until the requester takes it.
//   clk : clock, all state on rising edge
//   rst : synchronous active-high reset
//   bus : slave side of dmem_responder_if
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 0,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  dmem_responder_if.slave   bus
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic          req_ready_q, resp_valid_q, resp_err_q;
  logic [31:0]   resp_rdata_q;
  logic          req_ready_next, resp_valid_next;

  logic          accept_c, in_range_c, err_c;
  logic [31:0]   offset_c, word_idx_c, word_c, rdata_c;
  logic [3:0]    ram_we_c;

  // Request decode: range, strobe legality and the shifted read data.
  assign accept_c   = bus.req_valid && req_ready_q;
  assign offset_c   = bus.req_addr - BASE_ADDR;
  assign word_idx_c = offset_c >> 2;
  assign in_range_c = (bus.req_addr >= BASE_ADDR) && (word_idx_c < DEPTH_WORDS);
  assign err_c      = !in_range_c || !strobe_legal(bus.req_we);
  assign ram_we_c   = (accept_c && !err_c && !rst) ? bus.req_we : 4'b0000;
  assign rdata_c    = (in_range_c && bus.req_re)
                      ? (word_c >> {bus.req_addr[1:0], 3'b000}) : 32'h0;

  dmem_ram #(
    .DEPTH (DEPTH_WORDS),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .we      (ram_we_c),
    .waddr   (word_idx_c[AW-1:0]),
    .wdata   (bus.req_wdata),
    .raddr   (word_idx_c[AW-1:0]),
    .rdata_c (word_c)
  );

  // Next-state, wait counter and next values of the registered handshakes.
  always_comb begin
    state_next      = state;
    cnt_next        = cnt;
    req_ready_next  = 1'b0;
    resp_valid_next = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept_c) begin
          if (WAIT_CYCLES > 0) begin
            state_next = WAIT;
            cnt_next   = CW'(WAIT_CYCLES - 1);
          end else begin
            state_next = RESP;
          end
        end
      end
      WAIT: begin
        if (cnt == '0) state_next = RESP;
        else           cnt_next   = cnt - CW'(1);
      end
      RESP: begin
        if (bus.resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    req_ready_next  = (state_next == IDLE);
    resp_valid_next = (state_next == RESP);
  end

  // State register; response payload only changes at acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= 1'b0;
    end else begin
      state        <= state_next;
      cnt          <= cnt_next;
      req_ready_q  <= req_ready_next;
      resp_valid_q <= resp_valid_next;
      if (accept_c) begin
        resp_rdata_q <= rdata_c;
        resp_err_q   <= err_c;
      end
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;

endmodule
